// File: rtl/knight_input_ctrl_pkg.sv
// Shared definitions for the Knight input controller: HID keycodes and the
// decoded action type.
`timescale 1ns/1ps
package knight_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_J     = 8'h0D;
    localparam logic [7:0] KEY_K     = 8'h0E;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_JUMP,
        ACT_ATTACK,
        ACT_DASH
    } action_t;

endpackage

// File: rtl/knight_input_ctrl_if.sv
// Bundle between the keycode/motion side (master) and the input controller
// (slave), including read-only debug state for checkers.
`timescale 1ns/1ps
interface knight_input_ctrl_if #(
    parameter int CNT_W = 6
);
    // No valid/ready pair: frame_tick is the only qualifier. keycode and
    // on_ground are only meaningful on clk edges where frame_tick=1; the
    // controller never back-pressures, and its outputs change only in the
    // cycle after such an edge.
    logic [7:0]       keycode;
    logic             frame_tick;
    logic             on_ground;

    logic             move_left;
    logic             move_right;
    logic             facing_left;
    logic             jump_pulse;
    logic             attack_pulse;
    logic             dash_pulse;
    logic             jump_hold;

    logic [7:0]       dbg_key_q;
    logic [7:0]       dbg_prev_q;
    logic             dbg_air_dash_avail;
    logic [CNT_W-1:0] dbg_atk_cd;
    logic [CNT_W-1:0] dbg_dash_cd;
    logic [CNT_W-1:0] dbg_jbuf;
    logic             dbg_cfg_ok;

    modport master (
        output keycode, frame_tick, on_ground,
        input  move_left, move_right, facing_left,
        input  jump_pulse, attack_pulse, dash_pulse, jump_hold,
        input  dbg_key_q, dbg_prev_q, dbg_air_dash_avail,
        input  dbg_atk_cd, dbg_dash_cd, dbg_jbuf, dbg_cfg_ok
    );

    modport slave (
        input  keycode, frame_tick, on_ground,
        output move_left, move_right, facing_left,
        output jump_pulse, attack_pulse, dash_pulse, jump_hold,
        output dbg_key_q, dbg_prev_q, dbg_air_dash_avail,
        output dbg_atk_cd, dbg_dash_cd, dbg_jbuf, dbg_cfg_ok
    );

endinterface

// File: rtl/knight_input_ctrl_cooldown.sv
// frame_cooldown: saturating per-frame down-counter with load; ready when
// the count has reached zero.
`timescale 1ns/1ps
module frame_cooldown #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    // Load wins over the decrement so a fresh cooldown starts at full length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign ready = (count == '0);

endmodule

// File: rtl/knight_input_ctrl.sv
// Frame-synchronous keycode-to-action controller for the Knight.
// Optional airborne jump buffering is built when JUMP_BUFFER_EN is defined.
`timescale 1ns/1ps
module knight_input_ctrl
    import knight_pkg::*;
#(
    parameter int ATK_CD_FRAMES   = 12,
    parameter int DASH_CD_FRAMES  = 30,
    parameter int JUMP_BUF_FRAMES = 6,
    parameter int CNT_W           = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    knight_input_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam bit CFG_OK  = (ATK_CD_FRAMES   <= CNT_MAX) &&
                             (DASH_CD_FRAMES  <= CNT_MAX) &&
                             (JUMP_BUF_FRAMES <= CNT_MAX);

    function automatic action_t decode(input logic [7:0] key);
        case (key)
            KEY_A:            return ACT_LEFT;
            KEY_D:            return ACT_RIGHT;
            KEY_W, KEY_SPACE: return ACT_JUMP;
            KEY_J:            return ACT_ATTACK;
            KEY_K:            return ACT_DASH;
            default:          return ACT_NONE;
        endcase
    endfunction

    logic [7:0]       key_q;
    logic [7:0]       prev_q;
    logic             air_dash_avail;
    logic             move_left_q, move_right_q, facing_left_q, jump_hold_q;
    logic             jump_pulse_q, attack_pulse_q, dash_pulse_q;

    action_t          act_now, act_prev;
    logic             tick;
    logic             jump_edge, atk_edge, dash_edge;
    logic             atk_fire, dash_fire, jump_fire;
    logic [CNT_W-1:0] atk_cd, dash_cd;
    logic             atk_ready, dash_ready;
    logic             atk_ok, dash_ok;

    assign tick      = bus.frame_tick;
    assign act_now   = decode(bus.keycode);
    assign act_prev  = decode(key_q);
    assign jump_edge = (act_now == ACT_JUMP)   && (act_prev != ACT_JUMP);
    assign atk_edge  = (act_now == ACT_ATTACK) && (act_prev != ACT_ATTACK);
    assign dash_edge = (act_now == ACT_DASH)   && (act_prev != ACT_DASH);

    // The counter decrements on this same tick, so a count of 1 means the
    // cooldown expires now and the press is already allowed.
    assign atk_ok  = atk_ready  || (atk_cd  == CNT_W'(1));
    assign dash_ok = dash_ready || (dash_cd == CNT_W'(1));

    assign atk_fire  = tick && atk_edge && atk_ok;
    assign dash_fire = tick && dash_edge && dash_ok &&
                       (bus.on_ground || air_dash_avail);

    frame_cooldown #(.CNT_W(CNT_W)) u_atk_cd (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (atk_fire),
        .load_val (CNT_W'(ATK_CD_FRAMES)),
        .count    (atk_cd),
        .ready    (atk_ready)
    );

    frame_cooldown #(.CNT_W(CNT_W)) u_dash_cd (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (dash_fire),
        .load_val (CNT_W'(DASH_CD_FRAMES)),
        .count    (dash_cd),
        .ready    (dash_ready)
    );

`ifdef JUMP_BUFFER_EN
    logic [CNT_W-1:0] jbuf;
    logic             jbuf_empty;
    logic             jbuf_arm, jbuf_clear;

    // An airborne press arms the buffer; any grounded tick that fires a jump
    // (fresh press or pending buffer) empties it.
    assign jbuf_arm   = tick && jump_edge && !bus.on_ground;
    assign jump_fire  = tick && bus.on_ground && (jump_edge || !jbuf_empty);
    assign jbuf_clear = jump_fire;

    frame_cooldown #(.CNT_W(CNT_W)) u_jbuf (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (jbuf_arm || jbuf_clear),
        .load_val (jbuf_arm ? CNT_W'(JUMP_BUF_FRAMES) : '0),
        .count    (jbuf),
        .ready    (jbuf_empty)
    );

    assign bus.dbg_jbuf = jbuf;
`else
    assign jump_fire    = tick && bus.on_ground && jump_edge;
    assign bus.dbg_jbuf = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q          <= KEY_NONE;
            prev_q         <= KEY_NONE;
            air_dash_avail <= 1'b1;
            move_left_q    <= 1'b0;
            move_right_q   <= 1'b0;
            facing_left_q  <= 1'b0;
            jump_hold_q    <= 1'b0;
            jump_pulse_q   <= 1'b0;
            attack_pulse_q <= 1'b0;
            dash_pulse_q   <= 1'b0;
        end else begin
            jump_pulse_q   <= jump_fire;
            attack_pulse_q <= atk_fire;
            dash_pulse_q   <= dash_fire;
            if (tick) begin
                key_q        <= bus.keycode;
                prev_q       <= key_q;
                move_left_q  <= (act_now == ACT_LEFT);
                move_right_q <= (act_now == ACT_RIGHT);
                jump_hold_q  <= (act_now == ACT_JUMP);
                if (act_now == ACT_LEFT) begin
                    facing_left_q <= 1'b1;
                end else if (act_now == ACT_RIGHT) begin
                    facing_left_q <= 1'b0;
                end
                if (bus.on_ground) begin
                    air_dash_avail <= 1'b1;
                end else if (dash_fire) begin
                    air_dash_avail <= 1'b0;
                end
            end
        end
    end

    assign bus.move_left          = move_left_q;
    assign bus.move_right         = move_right_q;
    assign bus.facing_left        = facing_left_q;
    assign bus.jump_hold          = jump_hold_q;
    assign bus.jump_pulse         = jump_pulse_q;
    assign bus.attack_pulse       = attack_pulse_q;
    assign bus.dash_pulse         = dash_pulse_q;
    assign bus.dbg_key_q          = key_q;
    assign bus.dbg_prev_q         = prev_q;
    assign bus.dbg_air_dash_avail = air_dash_avail;
    assign bus.dbg_atk_cd         = atk_cd;
    assign bus.dbg_dash_cd        = dash_cd;
    assign bus.dbg_cfg_ok         = CFG_OK;

endmodule

// File: doc/knight_input_ctrl.md
# knight_input_ctrl

Frame-synchronous player-input controller for the Knight. It consumes the 8-bit USB HID keycode that the NIOS II software writes into the keycode PIO register, and samples it once per video frame. It converts the keycode into registered movement levels and single-cycle action pulses for the player-motion logic. Action pulses include jump, attack and dash, with edge detection, cooldowns and a jump buffer.

## Interface
- ATK_CD_FRAMES, 12: frames after an attack before the next attack is accepted.
- DASH_CD_FRAMES, 30: frames after a dash before the next dash is accepted.
- JUMP_BUF_FRAMES, 6: frames an airborne jump press stays pending (used only with JUMP_BUFFER_EN).
- CNT_W, 6: width of every frame counter. All frame parameters must be at most 2^CNT_W−1.
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- keycode  in  8  HID keycode from the keycode PIO out_port. 0x00 means no key.
- frame_tick  in  1  one-clk pulse per frame (start of vertical blank).
- on_ground  in  1  level from motion logic: Knight is standing on a surface.
- move_left / move_right  out  1  registered levels.
- facing_left  out  1  last horizontal direction held.
- jump_pulse / attack_pulse / dash_pulse  out  1  one-clk action pulses.
- jump_hold  out  1  jump key currently held (variable jump height).

## Operation
- Key map (HID usage IDs):
  - 0x04 (A) = left.
  - 0x07 (D) = right.
  - 0x1A (W) or 0x2C (Space) = jump.
  - 0x0D (J) = attack.
  - 0x0E (K) = dash.
  - Any other value = no action.
- Only one key is reported, so left and right cannot both be active.
- State updates only on clk edges where frame_tick=1. Keycode and on_ground are sampled there; changes between ticks are ignored.
- Sampling: key_q ← keycode and prev_q ← key_q.
- Press edge: decode(keycode) == action and decode(key_q) != action.
- Levels:
  - move_left/move_right follow decode(keycode).
  - jump_hold follows the jump key.
  - facing_left is set by a left sample and cleared by a right sample; otherwise it holds.
- Attack: on a press edge with atk_cd==0, fire attack_pulse and load atk_cd=ATK_CD_FRAMES. Otherwise the press is discarded.
- Dash:
  - Fires on a press edge with dash_cd==0 and (on_ground or air_dash_avail). It loads dash_cd=DASH_CD_FRAMES.
  - air_dash_avail is cleared by an airborne dash and set whenever on_ground=1 at a tick.
- Jump:
  - A press edge with on_ground=1 fires jump_pulse.
  - An airborne press is handled per Configuration.
- Counters decrement by 1 per tick and saturate at 0. A load takes priority over the decrement in the same tick.
- Holding a key never re-fires. A new pulse requires release (another keycode sampled) and a re-press.

## Timing
- Reset (reset_n=0 at a clk edge) clears every register in the same cycle:
  - all outputs = 0, with facing_left=0;
  - key_q=0x00;
  - all counters = 0;
  - air_dash_avail=1;
  - jump-buffer state cleared.
- Reset overrides a coincident frame_tick.
- Reset is honoured at any point; any action pending or in cooldown is abandoned.
- Latency: outputs reflect the keycode sampled at tick edge N from the cycle after edge N.
- Pulses are high for exactly the one clk after a tick edge, then 0 until a later tick.
- Levels hold until the next tick.
- A cooldown of C frames blocks presses at the next C−1 ticks; a press at tick N+C is accepted.

## Configuration
- Macro JUMP_BUFFER_EN.
- Defined:
  - An airborne jump press loads jbuf=JUMP_BUF_FRAMES.
  - Any tick with on_ground=1 and jbuf>0 fires jump_pulse and clears jbuf, even if the key has since been released.
  - A grounded press edge also clears jbuf.
- Undefined: airborne jump presses are discarded. No jbuf register exists.

## Structure
- Package knight_pkg holds:
  - keycode localparams (KEY_A, KEY_D, KEY_W, KEY_SPACE, KEY_J, KEY_K);
  - the action enum typedef (ACT_NONE, ACT_LEFT, ACT_RIGHT, ACT_JUMP, ACT_ATTACK, ACT_DASH).
- One sub-module, frame_cooldown: a saturating down-counter with load, tick and ready (count==0) ports. It is instantiated for attack, dash and (when enabled) the jump buffer.
- The keycode decode stays as a combinational function in the top module.

## Test plan
- Reset: hold keycode=0x0D while reset_n=0 across a tick. Required: all outputs 0, then attack_pulse only at the first post-reset tick.
- Hold 0x07 for 5 ticks, then 0x00. Required:
  - move_right=1 for the 5 frames;
  - facing_left=0;
  - no pulses.
- Attack cooldown (ATK_CD_FRAMES=12):
  - J at tick 0 → one attack_pulse.
  - Release and re-press at tick 5 → none.
  - Re-press at tick 12 → attack_pulse.
- Air dash: set on_ground=0.
  - Press K → dash_pulse.
  - After cooldown, press K again airborne → none.
  - Land, then press after cooldown → dash_pulse.
- Jump buffer (JUMP_BUFFER_EN, JUMP_BUF_FRAMES=6), Space pressed airborne at tick 0:
  - on_ground=1 at tick 4 → jump_pulse at tick 4.
  - on_ground=1 only at tick 7 → no pulse.
  - Without the macro → no pulse in either case.
- Mid-frame glitch: keycode goes 0x00→0x0D→0x00 between ticks. Required: no attack_pulse.
